div_ctrl: RTL

Run-time controller for the even clock divider in the AHB_APB subsystem. It owns the divide ratio, starts and stops the divided clock on period boundaries only, and accepts ratio reconfiguration through a pulse/ack handshake. Ratio changes take effect only at a period boundary, so the divided clock never shows a runt pulse. Outputs are the divided clock, a period-end strobe for downstream APB-side logic, and status.

---
 rtl/div_ctrl_pkg.sv | 18 +
 rtl/div_phase_cnt.sv | 40 ++++
 rtl/div_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types, default parameters and the divisor legality check for div_ctrl.
package div_ctrl_pkg;

    localparam int unsigned P_DIV_W   = 5;
    localparam int unsigned P_DEF_DIV = 4;
    localparam int unsigned P_MAX_DIV = 16;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Even and within 2..max_div.
    function automatic logic div_legal(input logic [31:0] value, input int unsigned max_div);
        return (value[0] == 1'b0) && (value >= 32'd2) && (value <= max_div);
    endfunction

endpackage

// File: rtl/div_phase_cnt.sv
// Phase counter for the divided clock: boundary detect plus registered clk_out/clk_en.
// Outputs are computed from next-cycle count and divisor so they line up with cnt.
module div_phase_cnt #(
    parameter int unsigned DIV_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_n,
    input  logic [DIV_W-1:0] i_n_nxt,
    input  logic             i_run,
    input  logic             i_clear,
    output logic             o_bnd_c,
    output logic             o_clk_out,
    output logic             o_clk_en
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             r_clk_out;
    logic             r_clk_en;

    assign o_bnd_c   = i_run && (r_cnt == (i_n - DIV_W'(1)));
    assign w_cnt_nxt = (!i_run || i_clear || o_bnd_c) ? '0 : (r_cnt + DIV_W'(1));

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_clk_en  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= !i_clear && (w_cnt_nxt >= (i_n_nxt >> 1));
            r_clk_en  <= !i_clear && (w_cnt_nxt == (i_n_nxt - DIV_W'(1)));
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_clk_en  = r_clk_en;

endmodule

// File: rtl/div_ctrl.sv
// Even clock divider controller: run/stop on period boundaries and glitch-free
// divisor reconfiguration through a req/ack handshake.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W   = P_DIV_W,
    parameter int unsigned DEF_DIV = P_DEF_DIV,
    parameter int unsigned MAX_DIV = P_MAX_DIV
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic             running,
    output logic [DIV_W-1:0] div_cur,
    output logic             clk_out,
    output logic             clk_en
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_pend_div_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             r_ack_dly;
    logic             w_ack_dly_nxt;
    logic             r_ack;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_running;
    logic             w_bnd;
    logic             w_acc;
    logic             w_legal;
    logic             w_run;
    logic             w_clear;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= STOP;
            r_div      <= DIV_W'(DEF_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_ack_dly  <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend     <= w_pend_nxt;
            r_ack_dly  <= w_ack_dly_nxt;
            r_ack      <= r_ack_dly;
            r_err      <= w_err_nxt;
            r_running  <= (w_state_nxt == RUN);
        end
    end

    // New requests are held off while an ack or err is in flight so both stay single, exclusive pulses.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_pend_div_nxt = r_pend_div;
        w_pend_nxt     = r_pend;
        w_ack_dly_nxt  = 1'b0;
        w_err_nxt      = 1'b0;
        w_legal        = div_legal(32'(cfg_div), MAX_DIV);
        w_acc          = cfg_req && !r_pend && !r_ack_dly && !r_err;

        case (r_state)
            STOP: begin
                if (r_pend) begin
                    w_div_nxt     = r_pend_div;
                    w_pend_nxt    = 1'b0;
                    w_ack_dly_nxt = 1'b1;
                end else if (w_acc && w_legal) begin
                    w_div_nxt     = cfg_div;
                    w_ack_dly_nxt = 1'b1;
                end
                if (run_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_bnd) begin
                    if (r_pend) begin
                        w_div_nxt     = r_pend_div;
                        w_pend_nxt    = 1'b0;
                        w_ack_dly_nxt = 1'b1;
                    end
                    if (!run_en) begin
                        w_state_nxt = STOP;
                    end
                end
                if (w_acc && w_legal) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_div_nxt = cfg_div;
                end
            end
            default: w_state_nxt = STOP;
        endcase

        if (w_acc && !w_legal) begin
            w_err_nxt = 1'b1;
        end
    end

    assign w_run   = (r_state == RUN);
    assign w_clear = (w_state_nxt == STOP);

    div_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_n       (r_div),
        .i_n_nxt   (w_div_nxt),
        .i_run     (w_run),
        .i_clear   (w_clear),
        .o_bnd_c   (w_bnd),
        .o_clk_out (clk_out),
        .o_clk_en  (clk_en)
    );

    assign cfg_ack = r_ack;
    assign cfg_err = r_err;
    assign busy    = r_pend;
    assign running = r_running;
    assign div_cur = r_div;

endmodule
